uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the up5k board. It sits directly upstream of the BSV top-level's byte interface, in the 48 MHz HFOSC domain. It synchronises the `serial_rxd` pin, deframes 8N1 UART characters (optionally 8E1), and buffers received bytes in a small first-word-fall-through FIFO with a valid/ready handshake. Framing, parity and overflow conditions are reported as single-cycle pulses.

## Interface
Parameters:
- `CLK_HZ`, 48000000, clock frequency in Hz.
- `BAUD`, 115200, line rate.
- `FIFO_DEPTH`, 4, number of output FIFO entries; must be a power of two, ≥2.
- Derived: `CPB = CLK_HZ/BAUD` (integer truncation; 416 at defaults) and `HALF = CPB/2` (208).

Ports:
- `CLK` in 1: single clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `serial_rxd` in 1: asynchronous UART line; idle high.
- `data_out` out 8: FIFO head byte; valid while `data_valid`=1.
- `data_valid` out 1: FIFO non-empty.
- `data_ready` in 1: consumer accepts head when `data_valid & data_ready`.
- `frame_err` out 1: 1-cycle pulse when the stop bit is sampled low.
- `parity_err` out 1: 1-cycle pulse on parity mismatch; tied 0 without `UART_RX_PARITY_EN`.
- `overflow` out 1: 1-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Input synchronisation:** `serial_rxd` passes through a 2-flop synchroniser to give `rxd_s`. Both flops reset to 1.
- **States:** IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
- **IDLE:**
  - An `armed` flag sets on any cycle with `rxd_s`=1 (reset clears it).
  - If `armed` and `rxd_s`=0: go to START and load the bit counter with HALF-1. This cycle is t0.
- **START:** at counter expiry (t0+HALF):
  - `rxd_s`=0 → DATA, bit index 0, counter loaded with CPB-1.
  - `rxd_s`=1 → glitch. Return to IDLE with no flag and no push.
- **DATA:** at each expiry, shift `rxd_s` in LSB-first. After bit 7, go to PARITY if enabled, else STOP.
- **PARITY:** sample the parity bit. Mismatch against even parity of the 8 data bits → `parity_err` pulse at the STOP sample cycle, and the byte is discarded.
- **STOP:** sample the stop bit.
  - `rxd_s`=1 and no parity error → push the byte into the FIFO and go to IDLE.
  - `rxd_s`=0 → `frame_err` pulse, byte discarded, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxd_s`=1, then go to IDLE. A break condition therefore yields exactly one `frame_err`.
- **FIFO:**
  - Pop on `data_valid & data_ready`.
  - Push when the FIFO is full and no pop occurs in the same cycle → byte dropped, `overflow` pulse.
  - Simultaneous push and pop when full is legal; the count is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. Count width is log2(DEPTH)+1.
- **Reset, including mid-frame:**
  - State → IDLE, `armed`=0, FIFO emptied.
  - `data_out`=0, `data_valid`=0, all error pulses 0.
  - The remainder of an interrupted frame is ignored until the line is seen high.

## Timing
- **Pin to `rxd_s`:** 2 cycles.
- **Sample points, relative to t0:**
  - Start check at t0+HALF.
  - Data bit i (0..7) at t0+HALF+(i+1)·CPB.
  - Parity at t0+HALF+9·CPB.
  - Stop at t0+HALF+9·CPB, or +10·CPB with parity.
- **Output latency:** `data_valid`/`data_out` update on the cycle after the stop sample. Error pulses assert on that same cycle.
- **Handshake:** `data_out` is stable while `data_valid`=1 and not popped. The next entry appears on the cycle after a pop.
- **Back-to-back frames:** a new start bit is accepted on the first cycle after returning to IDLE. No idle gap is required beyond the stop bit.

## Configuration
- `UART_RX_PARITY_EN` defined: 8E1 framing, PARITY state present, `parity_err` active.
- `UART_RX_PARITY_EN` undefined: 8N1 framing, PARITY state absent, `parity_err` constant 0.

## Test plan
- **Single byte:** 0x55 at 115200 with `data_ready`=0 → `data_valid` rises at t0+208+3744+1; `data_out`=0x55; no error pulses.
- **Framing error:** 0xA3 with the stop bit held low for 2 bit times → one `frame_err` pulse; FIFO stays empty; the next frame 0x3C is received correctly.
- **Overflow:** 5 back-to-back bytes 0x01..0x05 with `data_ready`=0 → `overflow` pulses once, on the 5th byte; draining yields 0x01, 0x02, 0x03, 0x04, then `data_valid`=0.
- **Glitch rejection:** line low for 100 cycles, then high → no push, no flags, state returns to IDLE.
- **Reset mid-frame:** `RST` pulsed during bit 3 of 0xFF, line held low for the remaining bits → no byte, no `frame_err`; after the line idles high, 0x7E is received correctly.
- **Parity (with macro):** 0x07 sent with parity bit 0 → `parity_err` pulse, no push; 0x07 with parity bit 1 → `data_out`=0x07.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with FWFT output FIFO; 8E1 framing when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       serial_rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overflow
);

    localparam int CPB   = CLK_HZ / BAUD;
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [1:0]       r_sync;
    logic [1:0]       r_sync_fill;
    logic             w_rxd_s;
    logic             w_sync_ok;

    state_t           r_state;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_par_bad;
    logic             r_frame_err;
    logic             r_parity_err;
    logic             w_tick;
    logic             w_push;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync      <= 2'b11;
            r_sync_fill <= 2'b00;
        end else begin
            r_sync      <= {r_sync[0], serial_rxd};
            r_sync_fill <= {r_sync_fill[0], 1'b1};
        end
    end

    // The synchroniser's reset value must not arm the receiver: only real line samples count.
    assign w_rxd_s   = r_sync[1];
    assign w_sync_ok = r_sync_fill[1];
    assign w_tick    = (r_cnt == '0);
    assign w_push    = (r_state == S_STOP) && w_tick && w_rxd_s && !r_par_bad;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            if (w_rxd_s && w_sync_ok)
                r_armed <= 1'b1;
            if (!w_tick)
                r_cnt <= r_cnt - CNT_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (r_armed && !w_rxd_s) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_W'(HALF - 1);
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!w_rxd_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                            r_par_bad <= 1'b0;
                            r_cnt     <= CNT_W'(CPB - 1);
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rxd_s, r_shift[7:1]};
                        r_cnt   <= CNT_W'(CPB - 1);
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_par_bad <= (w_rxd_s != ^r_shift);
                        r_cnt     <= CNT_W'(CPB - 1);
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        r_parity_err <= r_par_bad;
                        if (w_rxd_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rxd_s)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = data_valid && data_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge CLK) begin
        if (!RST && w_wr_en)
            r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr_en && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_wr_en && w_pop)
                r_count <= r_count - CW'(1);
        end
    end

    assign data_valid = (r_count != '0);
    assign data_out   = data_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (table vectors, corner sequences, random frames vs queue model).
module tb_uart_rx;

    localparam int CLK_HZ = 48000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 4;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int HALF   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       serial_rxd = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .serial_rxd(serial_rxd),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fe = 0, n_pe = 0, n_ov = 0;
    int rise_cyc = -1;
    bit prev_valid = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] mq[$];

    always @(negedge CLK) begin
        if (!RST) begin
            n_fe += int'(frame_err);
            n_pe += int'(parity_err);
            n_ov += int'(overflow);
            if (data_valid && !prev_valid)
                rise_cyc = cyc;
            if (data_valid && data_ready)
                got_q.push_back(data_out);
        end
        prev_valid = data_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic line_bits(input logic lvl, input int nbits);
        serial_rxd = lvl;
        step(nbits * CPB);
    endtask

    // Bad stop is held low for two bit times before the line returns to idle.
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        line_bits(1'b0, 1);
        for (int i = 0; i < 8; i++)
            line_bits(d[i], 1);
        if (PAR)
            line_bits((^d) ^ !par_ok, 1);
        if (stop_ok)
            line_bits(1'b1, 1);
        else
            line_bits(1'b0, 2);
        serial_rxd = 1'b1;
    endtask

    task automatic drain_check(input string name);
        data_ready = 1'b1;
        step(DEPTH + 3);
        data_ready = 1'b0;
        step(1);
        check({name, "_count"}, got_q.size(), mq.size());
        for (int i = 0; i < mq.size(); i++)
            if (i < got_q.size())
                check({name, "_byte"}, got_q[i], mq[i]);
        check({name, "_empty"}, data_valid, 0);
        mq.delete();
        got_q.delete();
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input bit par_ok, input bit stop_ok,
                             input bit drain, input bit exp_fe, input bit exp_pe, input bit exp_push);
        int fe0, pe0, ov0;
        bit exp_ov;
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        exp_ov = exp_push && (mq.size() == DEPTH);
        if (exp_push && !exp_ov)
            mq.push_back(d);
        send_frame(d, par_ok, stop_ok);
        step(3);
        check({name, "_frame_err"}, n_fe - fe0, int'(exp_fe));
        check({name, "_parity_err"}, n_pe - pe0, int'(exp_pe));
        check({name, "_overflow"}, n_ov - ov0, int'(exp_ov));
        check({name, "_valid"}, data_valid, int'(mq.size() != 0));
        if (mq.size() != 0)
            check({name, "_head"}, data_out, mq[0]);
        if (drain)
            drain_check(name);
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        bit         par_ok;
        bit         stop_ok;
        bit         drain;
        bit         exp_fe;
        bit         exp_pe;
        bit         exp_push;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int p, fe0, pe0, ov0;
        logic [7:0] rd;
        bit rs, rp, rdrain;

        vecs.push_back('{"frame_a3", 8'hA3, 1, 0, 0, 1, 0, 0});
        vecs.push_back('{"after_3c", 8'h3C, 1, 1, 1, 0, 0, 1});
        vecs.push_back('{"ovf_01",   8'h01, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{"ovf_02",   8'h02, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{"ovf_03",   8'h03, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{"ovf_04",   8'h04, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{"ovf_05",   8'h05, 1, 1, 1, 0, 0, 1});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{"par_bad",  8'h07, 0, 1, 0, 0, 1, 0});
        vecs.push_back('{"par_good", 8'h07, 1, 1, 1, 0, 0, 1});
`endif

        RST = 1'b1;
        serial_rxd = 1'b1;
        step(5);
        RST = 1'b0;
        step(5);
        check("reset_valid", data_valid, 0);
        check("reset_data", data_out, 0);
        check("reset_fe", frame_err, 0);
        check("reset_pe", parity_err, 0);
        check("reset_ov", overflow, 0);

        // t0 is two cycles after the pin edge; data_valid appears the cycle after the stop sample.
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        rise_cyc = -1;
        p = cyc;
        send_frame(8'h55, 1, 1);
        step(3);
        check("single_latency", rise_cyc, p + 2 + HALF + (PAR ? 10 : 9) * CPB + 1);
        check("single_valid", data_valid, 1);
        check("single_data", data_out, 8'h55);
        check("single_flags", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);
        mq.push_back(8'h55);
        drain_check("single");

        foreach (vecs[i])
            run_frame(vecs[i].name, vecs[i].data, vecs[i].par_ok, vecs[i].stop_ok,
                      vecs[i].drain, vecs[i].exp_fe, vecs[i].exp_pe, vecs[i].exp_push);

        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
        serial_rxd = 1'b0;
        step(100);
        serial_rxd = 1'b1;
        step(CPB);
        check("glitch_flags", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);
        check("glitch_valid", data_valid, 0);
        run_frame("post_glitch", 8'h5A, 1, 1, 1, 0, 0, 1);

        fe0 = n_fe;
        line_bits(1'b0, 1);
        for (int i = 0; i < 3; i++)
            line_bits(1'b1, 1);
        serial_rxd = 1'b1;
        step(CPB / 2);
        serial_rxd = 1'b0;
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        step(CPB / 2 + 4 * CPB + (PAR ? 2 : 1) * CPB);
        serial_rxd = 1'b1;
        step(CPB);
        check("rst_mid_fe", n_fe - fe0, 0);
        check("rst_mid_valid", data_valid, 0);
        mq.delete();
        got_q.delete();
        run_frame("post_reset_7e", 8'h7E, 1, 1, 1, 0, 0, 1);

        for (int i = 0; i < 3; i++) begin
            rd     = 8'($urandom_range(0, 255));
            rs     = ($urandom_range(0, 3) != 0);
            rp     = PAR ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdrain = (i == 2) || ($urandom_range(0, 1) == 1);
            run_frame("rand", rd, rp, rs, rdrain, !rs, PAR && !rp, rs && rp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
